hamming_encode_scheduler: RTL

Shares one `hamming_7_4_encoder` instance between two byte-wide requesters. Each accepted byte is split into two nibbles, and each nibble is encoded in turn. The resulting codewords are presented on a single valid/ready output stream, tagged with requester ID and a last flag. The block sits between the byte sources (e.g. TX framer, config shadow writer) and the codeword serializer.

---
 rtl/hamming_encode_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hamming_encode_scheduler.sv
// hamming_encode_scheduler
//   Shares one Hamming(7,4) encoder between two byte-wide requesters. Each
//   accepted byte is held and sent as two codewords, one per nibble, on a
//   single valid/ready stream tagged with requester ID and a last flag.
//
//   Optional build macro: HAM_SCHED_SECDED_EN
//     defined   : out_code[7] = even overall parity of out_code[6:0]
//     undefined : out_code[7] = 0
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req0_valid/data/ready  requester 0 byte handshake (ready = accepted)
//   req1_valid/data/ready  requester 1 byte handshake (ready = accepted)
//   out_valid/out_ready    codeword handshake
//   out_code               {parity-or-0, encoder[6:0]}
//   out_id                 requester that supplied the byte
//   out_last               second nibble of the byte
//   busy                   a byte is held
//   cw_count               codewords transferred since reset (wraps)

// Hamming(7,4): code_o[i-1] is codeword position i; parity bits sit at
// positions 1, 2 and 4, data bits d0..d3 at positions 3, 5, 6 and 7.
module hamming_7_4_encoder (
    input  logic [3:0] data_i,
    output logic [6:0] code_o
);
    logic p1, p2, p4;

    always_comb begin
        p1     = data_i[0] ^ data_i[1] ^ data_i[3];
        p2     = data_i[0] ^ data_i[2] ^ data_i[3];
        p4     = data_i[1] ^ data_i[2] ^ data_i[3];
        code_o = {data_i[3], data_i[2], data_i[1], p4, data_i[0], p2, p1};
    end
endmodule

module hamming_encode_scheduler #(
    parameter int unsigned LOW_NIBBLE_FIRST = 1,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_code,
    output logic             out_id,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] cw_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NIB0 = 2'd1,
        NIB1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hold_q;
    logic             hold_id_q;
    logic             rr_last_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [CNT_W-1:0] cw_count_q;

    logic       grant_any, grant_id;
    logic       accept_win, accept;
    logic [7:0] grant_data;
    logic       xfer;
    logic [3:0] nib_first, nib_second, enc_in;
    logic [6:0] enc_code;

    // Round-robin: on a tie the requester that did not win last time wins.
    always_comb begin
        grant_any = req0_valid | req1_valid;
        grant_id  = req1_valid & (~req0_valid | ~rr_last_q);
        grant_data = grant_id ? req1_data : req0_data;
    end

    // A new byte may enter when nothing is held, or when the last codeword
    // of the held byte leaves in this same cycle.
    always_comb begin
        accept_win = (state_q == IDLE) | ((state_q == NIB1) & out_ready);
        accept     = accept_win & grant_any & rst_n;
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;
        xfer       = out_valid_q & out_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = NIB0;
            NIB0: if (out_ready) state_d = NIB1;
            NIB1: if (out_ready) state_d = accept ? NIB0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_id_q   <= 1'b0;
            rr_last_q   <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cw_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != IDLE);
            out_last_q  <= (state_d == NIB1);
            if (accept) begin
                hold_q    <= grant_data;
                hold_id_q <= grant_id;
                rr_last_q <= grant_id;
            end
            if (xfer) begin
                cw_count_q <= cw_count_q + CNT_W'(1);
            end
        end
    end

    // Encoder sees only the held byte; no register follows it, so the
    // codeword stays stable for as long as hold and state do.
    always_comb begin
        if (LOW_NIBBLE_FIRST != 0) begin
            nib_first  = hold_q[3:0];
            nib_second = hold_q[7:4];
        end else begin
            nib_first  = hold_q[7:4];
            nib_second = hold_q[3:0];
        end
        enc_in = (state_q == NIB1) ? nib_second : nib_first;
    end

    hamming_7_4_encoder u_enc (
        .data_i (enc_in),
        .code_o (enc_code)
    );

`ifdef HAM_SCHED_SECDED_EN
    assign out_code = {^enc_code, enc_code};
`else
    assign out_code = {1'b0, enc_code};
`endif

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_id    = hold_id_q;
    assign busy      = (state_q != IDLE);
    assign cw_count  = cw_count_q;
endmodule
